// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable single-port RAM: write-mode encodings,
// clear-sequencer states and the lane-count helper.
package ram_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, owning the array port
// while it does so, then hands the port back to the user.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  output logic [ADDR_WIDTH-1:0] arr_addr,
  output logic                  clr_sel,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH:0] CNT_END = {1'b1, {ADDR_WIDTH{1'b0}}};

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET != 0) state_q <= ST_CLEAR;
      else                     state_q <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The extra counter bit marks completion; it saturates there instead of wrapping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_addr  = usr_addr;
    clr_sel   = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        init_busy = 1'b1;
        clr_sel   = 1'b1;
        arr_addr  = cnt_q[ADDR_WIDTH-1:0];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_d == CNT_END) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with per-lane write enables, selectable
// read-during-write return data, 1- or 2-cycle read latency and post-reset clear.
module sp_ram_be
  import ram_pkg::*;
#(
  parameter int                  DATA_WIDTH     = 72,
  parameter int                  ADDR_WIDTH     = 10,
  parameter int                  BYTE_WIDTH     = 9,
  parameter int                  RD_LATENCY     = 1,
  parameter int                  WRITE_MODE     = WM_READ_FIRST,
  parameter int                  CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
  localparam int                 NUM_BYTES      = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  wr_en,
  input  logic [NUM_BYTES-1:0]  be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
    $error("sp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sp_ram_be: RD_LATENCY must be 1 or 2");
  end

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NUM_BYTES-1:0]  lanes
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (lanes[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc;
  logic                  clr_sel;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [NUM_BYTES-1:0]  lane_we;
  logic [DATA_WIDTH-1:0] wdata;

  ram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .usr_addr  (addr),
    .arr_addr  (arr_addr),
    .clr_sel   (clr_sel),
    .init_busy (init_busy)
  );

  // Clear writer and user port share the single array port; clr_sel excludes acc.
  always_comb begin
    acc     = req & ~init_busy;
    lane_we = '0;
    wdata   = din;
    if (clr_sel) begin
      lane_we = '1;
      wdata   = CLEAR_VALUE;
    end else if (acc && wr_en) begin
      lane_we = be;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (lane_we[i]) mem[arr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // ---- stage p0: array output register plus write-merge side data ----
  logic [DATA_WIDTH-1:0] rdata_p0_q, rdata_p0_d;
  logic [DATA_WIDTH-1:0] wdin_p0_q, wdin_p0_d;
  logic [NUM_BYTES-1:0]  wbe_p0_q, wbe_p0_d;
  logic                  vld_p0_q, vld_p0_d;
  logic [DATA_WIDTH-1:0] ret_p0;

  // Write-first return is merged after the array read so the array stays read-first.
  always_comb begin
    rdata_p0_d = rdata_p0_q;
    wdin_p0_d  = wdin_p0_q;
    wbe_p0_d   = wbe_p0_q;
    vld_p0_d   = acc;
    if (acc) begin
      rdata_p0_d = mem[arr_addr];
      wdin_p0_d  = din;
      wbe_p0_d   = (WRITE_MODE == WM_WRITE_FIRST && wr_en) ? be : '0;
    end
    ret_p0 = byte_merge(rdata_p0_q, wdin_p0_q, wbe_p0_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p0_q <= '0;
      wdin_p0_q  <= '0;
      wbe_p0_q   <= '0;
      vld_p0_q   <= 1'b0;
    end else begin
      rdata_p0_q <= rdata_p0_d;
      wdin_p0_q  <= wdin_p0_d;
      wbe_p0_q   <= wbe_p0_d;
      vld_p0_q   <= vld_p0_d;
    end
  end

  // ---- stage p1: optional output pipeline register ----
  logic [DATA_WIDTH-1:0] dout_p1_q, dout_p1_d;
  logic                  vld_p1_q, vld_p1_d;

  always_comb begin
    dout_p1_d = vld_p0_q ? ret_p0 : dout_p1_q;
    vld_p1_d  = vld_p0_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      dout_p1_q <= dout_p1_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  always_comb begin
    dout       = (RD_LATENCY == 2) ? dout_p1_q : ret_p0;
    dout_valid = (RD_LATENCY == 2) ? vld_p1_q  : vld_p0_q;
  end

endmodule

// File: tb/tb_sp_ram_be.sv
// Bench for sp_ram_be: u1 uses the defaults (read-first, latency 1, 1024-word clear);
// u2 is write-first, latency 2, 16 words.
module tb_sp_ram_be;

  localparam int NB = 8;
  localparam int BW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n1, req1, we1, vld1, busy1;
  logic [7:0]  be1;
  logic [9:0]  addr1;
  logic [71:0] din1, dout1;
  logic        rst_n2, req2, we2, vld2, busy2;
  logic [7:0]  be2;
  logic [3:0]  addr2;
  logic [71:0] din2, dout2;

  sp_ram_be u1 (
    .clk(clk), .rst_n(rst_n1), .req(req1), .wr_en(we1), .be(be1), .addr(addr1),
    .din(din1), .dout(dout1), .dout_valid(vld1), .init_busy(busy1)
  );

  sp_ram_be #(.ADDR_WIDTH(4), .RD_LATENCY(2), .WRITE_MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n2), .req(req2), .wr_en(we2), .be(be2), .addr(addr2),
    .din(din2), .dout(dout2), .dout_valid(vld2), .init_busy(busy2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [71:0] data;
    int          due;
  } exp_t;

  exp_t        q1[$], q2[$];
  logic [71:0] mdl1[int], mdl2[int];

  function automatic logic [71:0] lane_mask(input logic [7:0] b);
    logic [71:0] m;
    m = '0;
    for (int i = 0; i < NB; i++)
      if (b[i]) m = m | ({63'd0, 9'h1FF} << (i * BW));
    return m;
  endfunction

  // Drive one request at a negedge; if it should be accepted, push its return word and due cycle.
  task automatic access(input int inst, input bit we, input logic [7:0] b, input int a,
                        input logic [71:0] d);
    logic [71:0] old, nw, m;
    exp_t        e;
    m = lane_mask(we ? b : 8'h00);
    if (inst == 1) old = mdl1.exists(a) ? mdl1[a] : 72'd0;
    else           old = mdl2.exists(a) ? mdl2[a] : 72'd0;
    nw = (old & ~m) | (d & m);
    if (inst == 1) begin
      e.due  = cyc + 1;
      e.data = old;
      q1.push_back(e);
      if (we) mdl1[a] = nw;
      req1 = 1'b1; we1 = we; be1 = b; addr1 = a[9:0]; din1 = d;
    end else begin
      e.due  = cyc + 2;
      e.data = nw;
      q2.push_back(e);
      if (we) mdl2[a] = nw;
      req2 = 1'b1; we2 = we; be2 = b; addr2 = a[3:0]; din2 = d;
    end
    @(negedge clk);
    req1 = 1'b0;
    req2 = 1'b0;
  endtask

  // Count cycles of u1 clear; optionally inject a dropped write or a reset partway through.
  task automatic meas1(input int drop_at, input int rst_at, output int n);
    n = 0;
    while (busy1 && n < 3000) begin
      if (n == rst_at) begin
        rst_n1 = 1'b0;
        #1;
        check("u1_midrst_dout", dout1, 72'd0);
        check("u1_midrst_vld", {71'd0, vld1}, 72'd0);
        check("u1_midrst_busy", {71'd0, busy1}, 72'd1);
        @(negedge clk);
        mdl1.delete();
        rst_n1 = 1'b1;
        return;
      end
      if (n == drop_at + 1 || n == drop_at + 2)
        check("u1_drop_novld", {71'd0, vld1}, 72'd0);
      req1 = (n == drop_at); we1 = 1'b1; be1 = 8'hFF; addr1 = 10'd3; din1 = 72'hAB_CDEF_0123_4567_89AB;
      n++;
      @(negedge clk);
    end
    req1 = 1'b0;
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (vld1 === 1'b1) begin
      if (q1.size() == 0) check("u1_unexpected_vld", {71'd0, vld1}, 72'd0);
      else begin
        e = q1.pop_front();
        check("u1_dout", dout1, e.data);
        check("u1_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (vld2 === 1'b1) begin
      if (q2.size() == 0) check("u2_unexpected_vld", {71'd0, vld2}, 72'd0);
      else begin
        e = q2.pop_front();
        check("u2_dout", dout2, e.data);
        check("u2_latency", cyc, e.due);
      end
    end
  end

  initial begin
    int n;
    rst_n1 = 1'b0; req1 = 1'b0; we1 = 1'b0; be1 = '0; addr1 = '0; din1 = '0;
    rst_n2 = 1'b0; req2 = 1'b0; we2 = 1'b0; be2 = '0; addr2 = '0; din2 = '0;
    repeat (3) @(negedge clk);
    check("u1_rst_dout", dout1, 72'd0);
    check("u1_rst_vld", {71'd0, vld1}, 72'd0);
    check("u1_rst_busy", {71'd0, busy1}, 72'd1);
    check("u2_rst_dout", dout2, 72'd0);
    check("u2_rst_busy", {71'd0, busy2}, 72'd1);

    // u2: write-first, latency 2
    rst_n2 = 1'b1;
    n = 0;
    while (busy2 && n < 200) begin n++; @(negedge clk); end
    check("u2_busy_len", n, 16);
    access(2, 1, 8'hFF, 1, 72'd10);
    access(2, 1, 8'hFF, 2, 72'd20);
    access(2, 1, 8'hFF, 3, 72'd30);
    repeat (3) @(negedge clk);
    access(2, 0, 8'h00, 1, 72'd0);
    access(2, 0, 8'h00, 2, 72'd0);
    access(2, 0, 8'h00, 3, 72'd0);
    access(2, 1, 8'hFF, 7, 72'h1);
    access(2, 1, 8'hFF, 7, 72'h2);
    access(2, 1, 8'hFF, 5, {72{1'b1}});
    access(2, 1, 8'b0000_0101, 5, 72'd0);
    access(2, 1, 8'h00, 5, {72{1'b1}});
    access(2, 0, 8'h00, 5, 72'd0);
    access(2, 0, 8'h00, 9, 72'd0);
    repeat (4) @(negedge clk);

    // u1: initial clear, junk, reset, clear with a dropped write
    rst_n1 = 1'b1;
    meas1(-10, -1, n);
    check("u1_busy_len", n, 1024);
    access(1, 1, 8'hFF, 0,    72'h12_3456_789A_BCDE_F012);
    access(1, 1, 8'hFF, 511,  72'h5A_5A5A_5A5A_5A5A_5A5A);
    access(1, 1, 8'hFF, 1023, 72'hC3_C3C3_C3C3_C3C3_C3C3);
    access(1, 0, 8'h00, 511,  72'd0);
    repeat (3) @(negedge clk);
    check("u1_dout_hold", dout1, 72'h5A_5A5A_5A5A_5A5A_5A5A);
    rst_n1 = 1'b0;
    #1;
    check("u1_rst2_dout", dout1, 72'd0);
    check("u1_rst2_busy", {71'd0, busy1}, 72'd1);
    @(negedge clk);
    mdl1.delete();
    rst_n1 = 1'b1;
    meas1(100, -1, n);
    check("u1_busy_len2", n, 1024);
    access(1, 0, 8'h00, 0, 72'd0);
    access(1, 0, 8'h00, 511, 72'd0);
    access(1, 0, 8'h00, 1023, 72'd0);
    access(1, 0, 8'h00, 3, 72'd0);

    // byte enables and read-first read-during-write
    access(1, 1, 8'hFF, 5, {72{1'b1}});
    access(1, 1, 8'b0000_0101, 5, 72'd0);
    access(1, 0, 8'h00, 5, 72'd0);
    access(1, 1, 8'hFF, 7, 72'h1);
    access(1, 1, 8'hFF, 7, 72'h2);
    access(1, 1, 8'h00, 7, {72{1'b1}});
    access(1, 0, 8'h00, 7, 72'd0);
    repeat (3) @(negedge clk);

    // reset partway through the clear, then a full clear again
    rst_n1 = 1'b0;
    @(negedge clk);
    mdl1.delete();
    rst_n1 = 1'b1;
    meas1(-10, 500, n);
    check("u1_partial_len", n, 500);
    meas1(-10, -1, n);
    check("u1_busy_len3", n, 1024);
    access(1, 0, 8'h00, 1023, 72'd0);
    access(1, 0, 8'h00, 5, 72'd0);
    repeat (5) @(negedge clk);
    check("u1_drain", q1.size(), 0);
    check("u2_drain", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
